tpu_job_sequencer: RTL

- Autonomous job controller in front of tpuv1's memory-mapped bus (clk, r_w, addr, dataIn, dataOut).
- Accepts DIM A rows and DIM B rows from a valid/ready input stream and writes them into the array.
- Issues the matmul start write, waits out the compute latency, then streams the 2*DIM C half-rows out on a valid/ready output stream.
- Replaces hand-driven bus sequencing from the host/testbench; one job in flight at a time.

---
 rtl/tpu_job_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/tpu_job_sequencer.sv
// tpu_job_sequencer: runs one matmul job on the tpuv1 memory-mapped bus.
// It loads DIM A rows and DIM B rows from an input stream and writes the
// start command. It then waits out the compute latency and streams the
// 2*DIM C half-rows to an output stream.
module tpu_job_sequencer #(
  parameter int DIM     = 8,
  parameter int ADDRW   = 16,
  parameter int DATAW   = 64,
  parameter int MM_WAIT = 3*DIM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic             out_last,
  output logic             tpu_r_w,
  output logic [ADDRW-1:0] tpu_addr,
  output logic [DATAW-1:0] tpu_dataIn,
  input  logic [DATAW-1:0] tpu_dataOut
);

  localparam int CW = $clog2(2*DIM);
  localparam int WW = $clog2(MM_WAIT+1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_A   = 3'd1;
  localparam logic [2:0] S_LOAD_B   = 3'd2;
  localparam logic [2:0] S_START_MM = 3'd3;
  localparam logic [2:0] S_WAIT_MM  = 3'd4;
  localparam logic [2:0] S_READ_C   = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam logic [CW-1:0]    C_LAST_ROW  = CW'(DIM-1);
  localparam logic [CW-1:0]    C_LAST_BEAT = CW'(2*DIM-1);
  localparam logic [WW-1:0]    W_INIT      = WW'(MM_WAIT-1);
  localparam logic [ADDRW-1:0] A_BASE      = ADDRW'(16'h0100);
  localparam logic [ADDRW-1:0] B_ADDR      = ADDRW'(16'h0200);
  localparam logic [ADDRW-1:0] C_BASE      = ADDRW'(16'h0300);
  localparam logic [ADDRW-1:0] MM_ADDR     = ADDRW'(16'h0400);

  logic [2:0]       r_state;
  logic [CW-1:0]    r_cnt;    // A row in LOAD_A, B beats in LOAD_B, C beat k in READ_C
  logic [WW-1:0]    r_wait;
  logic [ADDRW-1:0] w_cnt_addr;

  // Beat counter scaled to an 8-byte stride. The C address 0x0300|(row<<4)|(half<<3) equals 0x0300|(k<<3).
  assign w_cnt_addr = ADDRW'({r_cnt, 3'b000});

  // Job state machine and counters. The beat counter clears on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wait  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD_A;
            r_cnt   <= '0;
          end
        end
        S_LOAD_A: begin
          if (in_valid) begin
            if (r_cnt == C_LAST_ROW) begin
              r_state <= S_LOAD_B;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_LOAD_B: begin
          if (in_valid) begin
            if (r_cnt == C_LAST_ROW) begin
              r_state <= S_START_MM;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_START_MM: begin
          r_state <= S_WAIT_MM;
          r_wait  <= W_INIT;
        end
        S_WAIT_MM: begin
          if (r_wait == '0) begin
            r_state <= S_READ_C;
            r_cnt   <= '0;
          end else begin
            r_wait <= r_wait - WW'(1);
          end
        end
        S_READ_C: begin
          if (out_ready) begin
            if (r_cnt == C_LAST_BEAT) begin
              r_state <= S_DONE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_wait  <= '0;
        end
      endcase
    end
  end

  // Bus and stream outputs decoded from state. Any cycle without a write or C read drives the idle bus.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    tpu_r_w    = 1'b0;
    tpu_addr   = '0;
    tpu_dataIn = '0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_LOAD_A: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          tpu_r_w    = 1'b1;
          tpu_addr   = A_BASE | w_cnt_addr;
          tpu_dataIn = in_data;
        end else begin
          tpu_r_w = 1'b0;
        end
      end
      S_LOAD_B: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        // B shifts on every write, so a bubble must leave the bus idle.
        if (in_valid) begin
          tpu_r_w    = 1'b1;
          tpu_addr   = B_ADDR;
          tpu_dataIn = in_data;
        end else begin
          tpu_r_w = 1'b0;
        end
      end
      S_START_MM: begin
        busy     = 1'b1;
        tpu_r_w  = 1'b1;
        tpu_addr = MM_ADDR;
      end
      S_WAIT_MM: begin
        busy = 1'b1;
      end
      S_READ_C: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        tpu_addr  = C_BASE | w_cnt_addr;
        out_data  = tpu_dataOut;
        out_last  = (r_cnt == C_LAST_BEAT);
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule
